pl_mem_lsu: RTL and testbench

PL_MEM_LSU -- requirements
Module: pl_mem_lsu

---
 rtl/pl_mem_lsu_pkg.sv | 44 ++++
 rtl/pl_mem_lsu_load_align.sv | 32 +++
 rtl/pl_mem_lsu.sv | 171 +++++++++++++++++
 tb/tb_pl_mem_lsu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pl_mem_lsu_pkg.sv
// Shared encodings for the M-stage load/store unit: funct3 sizes, FSM states,
// access-size classification and the bus timeout limit.
package pl_mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic lsu_size_e access_size(input logic [2:0] f3, input logic is_store);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                F3_B:    sz = SZ_BYTE;
                F3_H:    sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: sz = SZ_BYTE;
                F3_H, F3_HU: sz = SZ_HALF;
                default:     sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/pl_mem_lsu_load_align.sv
// Combinational load lane selection and sign/zero extension of the bus read word.
module lsu_load_align
    import pl_mem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_byte_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/pl_mem_lsu.sv
// M-stage load/store unit: single-outstanding bus access with stall, timeout and lane steering.
// Build option: LSU_MISALIGN_TRAP_EN adds MisalignM and suppresses misaligned accesses.
module pl_mem_lsu
    import pl_mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        MisalignM
`endif
);

    lsu_state_e r_state, w_state_nxt;
    logic        r_active;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_f3;

    logic        w_access;
    logic        w_trap;
    logic        w_latch;
    logic        w_zero_rd;
    lsu_size_e   w_size;
    logic [31:0] w_addr_eff;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [1:0]  w_sel_off;
    logic [2:0]  w_sel_f3;
    logic [31:0] w_load_data;

    assign w_access = MemReadM | MemWriteM;
    assign w_size   = access_size(funct3M, MemWriteM);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((w_size == SZ_HALF) && ALUResultM[0]) ||
                    ((w_size == SZ_WORD) && (ALUResultM[1:0] != 2'b00));
    assign MisalignM = r_active && (r_state == ST_IDLE) && w_access && w_trap;
`else
    assign w_trap = 1'b0;
`endif

    // Low address bits below the access size are dropped, so a misaligned access lands aligned-down.
    always_comb begin
        w_addr_eff = ALUResultM;
        w_wdata    = WriteDataM;
        w_wstrb    = 4'b1111;
        case (w_size)
            SZ_BYTE: begin
                w_wdata = {4{WriteDataM[7:0]}};
                w_wstrb = 4'b0001 << ALUResultM[1:0];
            end
            SZ_HALF: begin
                w_addr_eff[0] = 1'b0;
                w_wdata       = {2{WriteDataM[15:0]}};
                w_wstrb       = 4'b0011 << {ALUResultM[1], 1'b0};
            end
            default: w_addr_eff[1:0] = 2'b00;
        endcase
        if (!MemWriteM) w_wstrb = '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        StallM      = 1'b0;
        BusErrM     = 1'b0;
        w_latch     = 1'b0;
        w_zero_rd   = 1'b0;
        w_sel_off   = w_addr_eff[1:0];
        w_sel_f3    = funct3M;

        if (r_active) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access && w_trap) begin
                        w_zero_rd = 1'b1;
                    end else if (w_access) begin
                        mem_req   = 1'b1;
                        mem_we    = MemWriteM;
                        mem_addr  = {w_addr_eff[31:2], 2'b00};
                        mem_wdata = w_wdata;
                        mem_wstrb = w_wstrb;
                        if (!mem_ready) begin
                            StallM      = 1'b1;
                            w_latch     = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    w_sel_off = r_addr[1:0];
                    w_sel_f3  = r_f3;
                    if (!mem_ready && (r_wait_cnt == TIMEOUT_MAX)) begin
                        BusErrM     = 1'b1;
                        w_zero_rd   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        mem_req   = 1'b1;
                        mem_we    = r_we;
                        mem_addr  = {r_addr[31:2], 2'b00};
                        mem_wdata = r_wdata;
                        mem_wstrb = r_wstrb;
                        StallM    = !mem_ready;
                        if (mem_ready) w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // r_active holds the outputs quiet until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_we       <= 1'b0;
            r_f3       <= '0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_latch) begin
                r_wait_cnt <= '0;
                r_addr     <= w_addr_eff;
                r_wdata    <= w_wdata;
                r_wstrb    <= w_wstrb;
                r_we       <= MemWriteM;
                r_f3       <= funct3M;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    lsu_load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_byte_off (w_sel_off),
        .i_funct3   (w_sel_f3),
        .o_data     (w_load_data)
    );

    assign ReadDataM = w_zero_rd ? '0 : w_load_data;

endmodule

// File: tb/tb_pl_mem_lsu.sv
// Scoreboard bench for pl_mem_lsu: directed accesses push expectations, a negedge monitor checks completions.
module tb_pl_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM;
    logic        misal_w;
    logic        ev;

    always #5 clk = ~clk;

    pl_mem_lsu u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .MisalignM  (misal_w)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign misal_w = 1'b0;
`endif

    assign ev = (mem_req && mem_ready) || BusErrM || misal_w;

    typedef struct {
        string       name;
        logic        err;
        logic        misal;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        else n_pass++;
    endtask

    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_cnt = 0;
            end else if (ev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_stall_cycles"}, stall_cnt, e.stalls);
                    chk({e.name, "_StallM_at_done"}, 32'(StallM), 32'd0);
                    chk({e.name, "_BusErrM"}, 32'(BusErrM), 32'(e.err));
                    chk({e.name, "_mem_req"}, 32'(mem_req), 32'(!(e.err || e.misal)));
                    if (!e.err && !e.misal) begin
                        chk({e.name, "_mem_addr"}, mem_addr, e.addr);
                        chk({e.name, "_mem_we"}, 32'(mem_we), 32'(e.we));
                        if (e.we) begin
                            chk({e.name, "_mem_wdata"}, mem_wdata, e.wdata);
                            chk({e.name, "_mem_wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
                        end
                    end
                    if (!e.we) chk({e.name, "_ReadDataM"}, ReadDataM, e.rdata);
`ifdef LSU_MISALIGN_TRAP_EN
                    chk({e.name, "_MisalignM"}, 32'(misal_w), 32'(e.misal));
`endif
                end
                stall_cnt = 0;
            end else if (StallM) begin
                stall_cnt++;
            end
        end
    end

    // delay: cycles after issue before mem_ready pulses (negative = never).
    task automatic issue(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int delay, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb, input logic [31:0] e_rdata, input int e_stalls,
                         input logic e_err, input logic e_misal);
        exp_t e;
        int   cyc;
        logic done;
        e.name = nm; e.err = e_err; e.misal = e_misal; e.addr = e_addr; e.we = wr;
        e.wdata = e_wdata; e.wstrb = e_wstrb; e.rdata = e_rdata; e.stalls = e_stalls;
        sb_q.push_back(e);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        mem_rdata = rdat; mem_ready = (delay == 0);
        cyc = 0; done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (ev) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            mem_ready = (cyc == delay);
        end
        chk({nm, "_completed"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b1; funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b1;
        #12;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_StallM", 32'(StallM), 32'd0);
        chk("reset_BusErrM", 32'(BusErrM), 32'd0);
        MemWriteM = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b1;

        issue("sw_0x100", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
              32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0, 0);
        issue("lb_0x103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 3,
              32'h100, 32'h0, 4'b0000, 32'hFFFFFF80, 3, 0, 0);
        issue("lbu_0x103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 3,
              32'h100, 32'h0, 4'b0000, 32'h00000080, 3, 0, 0);
        issue("sh_0x102", 0, 1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 1,
              32'h100, 32'h12341234, 4'b1100, 32'h0, 1, 0, 0);
        issue("sb_0x101", 0, 1, 3'b000, 32'h101, 32'h1234_56A5, 32'h0, 2,
              32'h100, 32'hA5A5A5A5, 4'b0010, 32'h0, 2, 0, 0);
        issue("lh_0x102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0,
              32'h100, 32'h0, 4'b0000, 32'hFFFF8001, 0, 0, 0);
        issue("lhu_0x100", 1, 0, 3'b101, 32'h100, 32'h0, 32'h8001_F00D, 0,
              32'h100, 32'h0, 4'b0000, 32'h0000F00D, 0, 0, 0);
        issue("lw_0x104", 1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 1,
              32'h104, 32'h0, 4'b0000, 32'hCAFEF00D, 1, 0, 0);
        issue("ld_f3_111", 1, 0, 3'b111, 32'h108, 32'h0, 32'h1122_3344, 0,
              32'h108, 32'h0, 4'b0000, 32'h11223344, 0, 0, 0);
        issue("rd_wr_both", 1, 1, 3'b010, 32'h10C, 32'h55AA_55AA, 32'h0, 0,
              32'h10C, 32'h55AA55AA, 4'b1111, 32'h0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue("lw_misal", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0102_0304, 0,
              32'h0, 32'h0, 4'b0000, 32'h0, 0, 0, 1);
        @(negedge clk);
        chk("misal_pulse_width", 32'(misal_w), 32'd0);
`else
        issue("lw_misal", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0102_0304, 0,
              32'h100, 32'h0, 4'b0000, 32'h01020304, 0, 0, 0);
`endif
        issue("lw_timeout", 1, 0, 3'b010, 32'h200, 32'h0, 32'hFFFF_FFFF, -1,
              32'h200, 32'h0, 4'b0000, 32'h0, 256, 1, 0);
        @(negedge clk);
        chk("buserr_pulse_width", 32'(BusErrM), 32'd0);
        chk("after_timeout_StallM", 32'(StallM), 32'd0);

        // mem_ready with no access must be ignored.
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_mem_req", 32'(mem_req), 32'd0);
        chk("idle_ready_StallM", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;

        // Abort a load in WAIT with reset, then check release timing.
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h200;
        repeat (5) @(posedge clk);
        #2;
        chk("wait5_mem_req", 32'(mem_req), 32'd1);
        chk("wait5_StallM", 32'(StallM), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_StallM", 32'(StallM), 32'd0);
        chk("async_rst_BusErrM", 32'(BusErrM), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        #1;
        chk("release_pre_edge_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk("release_post_edge_mem_req", 32'(mem_req), 32'd1);
        chk("release_post_edge_addr", mem_addr, 32'h200);
        MemReadM = 1'b0;

        issue("lw_after_reset", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0BAD_CAFE, 1,
              32'h300, 32'h0, 4'b0000, 32'h0BADCAFE, 1, 0, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
